// File: rtl/aes_spi_master.sv
// SPI initiator for the AES decrypt core: key frame, gap, message frame, decipher wait, read frame.
// sclk is clk/(2*CLK_DIV); the host sees busy while a transaction runs and a one-cycle done (and err) at the end.
module aes_spi_master #(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 258,
  parameter int GAP_SCLK   = 4,
  parameter int WAIT_SCLK  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_size,
  input  logic [255:0] key,
  input  logic [127:0] msg_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] msg_out,
  output logic         cs,
  output logic         sclk,
  output logic         sdo,
  input  logic         sdi
);

  typedef enum logic [2:0] {IDLE, KEY, GAP, MSG, WAIT, READ, FIN} state_t;
  // RUN toggles sclk; TRAIL holds cs low one half-period; POST idles one half-period with cs high
  typedef enum logic [1:0] {RUN, TRAIL, POST} sub_t;

  localparam int             DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [8:0]     BIT_LAST  = 9'(FRAME_BITS - 1);
  localparam logic [8:0]     GAP_LAST  = 9'(GAP_SCLK - 1);
  localparam logic [8:0]     WAIT_LAST = 9'(WAIT_SCLK - 1);

  state_t                state;
  sub_t                  sub;
  logic [DW-1:0]         div_cnt;
  logic [8:0]            bit_cnt;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [127:0]          msg_q;
  logic [127:0]          rx_sr;
  logic                  tick;
  logic [FRAME_BITS-1:0] msg_frame;

  assign tick      = (div_cnt == DIV_LAST);
  assign msg_frame = {{(FRAME_BITS-128){1'b0}}, msg_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sub     <= RUN;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      msg_q   <= '0;
      rx_sr   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      msg_out <= '0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + DW'(1);
      case (state)
        IDLE: begin
          if (start) begin
            if (key_size == 2'b11) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= FIN;
            end else begin
              busy    <= 1'b1;
              cs      <= 1'b0;
              tx_sr   <= {key_size, key};
              sdo     <= key_size[1];
              msg_q   <= msg_in;
              bit_cnt <= '0;
              sub     <= RUN;
              state   <= KEY;
            end
          end
        end
        KEY, MSG, READ: begin
          if (tick) begin
            case (sub)
              RUN: begin
                if (!sclk) begin
                  sclk <= 1'b1;
                  if (state == READ && bit_cnt < 9'd128) rx_sr <= {rx_sr[126:0], sdi};
                end else begin
                  sclk <= 1'b0;
                  if (bit_cnt == BIT_LAST) begin
                    bit_cnt <= '0;
                    sdo     <= 1'b0;
                    sub     <= TRAIL;
                  end else begin
                    bit_cnt <= bit_cnt + 9'd1;
                    sdo     <= tx_sr[FRAME_BITS-2];
                    tx_sr   <= tx_sr << 1;
                  end
                end
              end
              TRAIL: begin
                cs  <= 1'b1;
                sub <= POST;
              end
              default: begin
                sub <= RUN;
                case (state)
                  KEY:     state <= GAP;
                  MSG:     state <= WAIT;
                  default: begin
                    state   <= FIN;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    msg_out <= rx_sr;
                  end
                endcase
              end
            endcase
          end
        end
        GAP, WAIT: begin
          // sclk keeps running with cs high so the core can advance; the next frame opens on the last fall
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == ((state == GAP) ? GAP_LAST : WAIT_LAST)) begin
                bit_cnt <= '0;
                cs      <= 1'b0;
                if (state == GAP) begin
                  state <= MSG;
                  tx_sr <= msg_frame;
                  sdo   <= msg_frame[FRAME_BITS-1];
                end else begin
                  state <= READ;
                  tx_sr <= '0;
                  sdo   <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 9'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_master.sv
// Directed bench: behavioural SPI subordinate answers known FIPS-197 vectors; checks frames, timing and control pulses.
module tb_aes_spi_master;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_size = 2'b00;
  logic [255:0] key = '0;
  logic [127:0] msg_in = '0;
  logic         busy, done, err, cs, sclk, sdo;
  logic         sdi = 1'b0;
  logic [127:0] msg_out;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BAD   = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
  // 2*CLK_DIV*(3*258+4+32) + 3*2*CLK_DIV with CLK_DIV=2
  localparam int           LAT   = 3252;

  always #5 clk = ~clk;

  aes_spi_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_size(key_size), .key(key),
    .msg_in(msg_in), .busy(busy), .done(done), .err(err), .msg_out(msg_out),
    .cs(cs), .sclk(sclk), .sdo(sdo), .sdi(sdi)
  );

  // Subordinate model state
  logic [257:0] cap = '0;
  logic [257:0] resp = '0;
  logic [257:0] frames [3];
  int           rises [3];
  int           hi_rises [3];
  int           fidx = 0, nrise = 0, nhi = 0, sclk_edges = 0, done_cnt = 0;
  logic         cs_q = 1'b1, sclk_q = 1'b0, busy_q = 1'b0;

  function automatic logic [127:0] lookup(input logic [257:0] kf, input logic [257:0] mf);
    if (kf == {2'b00, K128} && mf == {130'b0, CT128}) return PT;
    if (kf == {2'b10, K256} && mf == {130'b0, CT256}) return PT;
    return BAD;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      frames[i] = '0; rises[i] = 0; hi_rises[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (sclk !== sclk_q) sclk_edges++;
      if (busy && !busy_q) begin fidx = 0; nhi = 0; end
      if (cs_q && !cs) begin
        if (fidx < 3) hi_rises[fidx] = nhi;
        nrise = 0;
        cap = '0;
        if (fidx == 2) begin
          resp = {lookup(frames[0], frames[1]), {130{1'b1}}};
          sdi = resp[257];
        end
      end else if (!cs && !cs_q && sclk_q && !sclk) begin
        resp = {resp[256:0], 1'b1};
        sdi = resp[257];
      end
      if (!sclk_q && sclk) begin
        if (!cs) begin cap = {cap[256:0], sdo}; nrise++; end
        else nhi++;
      end
      if (!cs_q && cs) begin
        if (fidx < 3) begin frames[fidx] = cap; rises[fidx] = nrise; end
        fidx++;
        nhi = 0;
        sdi = 1'b0;
      end
      cs_q = cs; sclk_q = sclk; busy_q = busy;
    end
  end

  task automatic do_start(input logic [1:0] ks, input logic [255:0] k, input logic [127:0] m);
    @(negedge clk);
    key_size = ks; key = k; msg_in = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", cs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", sdo); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, err}); end
    checks++; if (msg_out !== '0) begin errors++; $display("FAIL reset_msg_out: got %h expected 0", msg_out); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_aes128;
    int cyc, d0;
    d0 = done_cnt;
    do_start(2'b00, K128, CT128);
    checks++; if (busy !== 1'b1 || cs !== 1'b0) begin errors++; $display("FAIL a128_busy_cs: got busy=%b cs=%b expected 1/0", busy, cs); end
    wait_done(cyc);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL a128_timeout: got no done after %0d cycles expected done", cyc); end
    checks++; if (cyc != LAT) begin errors++; $display("FAIL a128_latency: got %0d expected %0d", cyc, LAT); end
    checks++; if (msg_out !== PT) begin errors++; $display("FAIL a128_msg_out: got %h expected %h", msg_out, PT); end
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL a128_err_busy: got err=%b busy=%b expected 0/0", err, busy); end
    checks++; if (frames[0] !== {2'b00, K128}) begin errors++; $display("FAIL a128_key_frame: got %h expected %h", frames[0], {2'b00, K128}); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL a128_done_width: got %b expected 0", done); end
    repeat (5) @(posedge clk); #1;
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL a128_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_aes256_frames;
    int cyc;
    do_start(2'b10, K256, CT256);
    wait_done(cyc);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL a256_timeout: got no done after %0d cycles expected done", cyc); end
    checks++; if (msg_out !== PT) begin errors++; $display("FAIL a256_msg_out: got %h expected %h", msg_out, PT); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rises[i] != 258) begin errors++; $display("FAIL a256_rises%0d: got %0d expected 258", i, rises[i]); end
    end
    checks++; if (frames[0][257:256] !== 2'b10) begin errors++; $display("FAIL order_size_bits: got %b expected 10", frames[0][257:256]); end
    checks++; if (frames[0][255:0] !== K256) begin errors++; $display("FAIL order_key_bits: got %h expected %h", frames[0][255:0], K256); end
    checks++; if (frames[1][257:128] !== '0) begin errors++; $display("FAIL order_msg_zeros: got %h expected 0", frames[1][257:128]); end
    checks++; if (frames[1][127:0] !== CT256) begin errors++; $display("FAIL order_msg_bits: got %h expected %h", frames[1][127:0], CT256); end
    checks++; if (frames[2] !== '0) begin errors++; $display("FAIL read_sdo_zero: got %h expected 0", frames[2]); end
    checks++; if (hi_rises[1] != 4) begin errors++; $display("FAIL gap_sclk: got %0d expected 4", hi_rises[1]); end
    checks++; if (hi_rises[2] != 32) begin errors++; $display("FAIL wait_sclk: got %0d expected 32", hi_rises[2]); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_illegal;
    int e0;
    e0 = sclk_edges;
    do_start(2'b11, K256, CT128);
    checks++; if ({done, err} !== 2'b11) begin errors++; $display("FAIL ill_pulse: got done/err=%b expected 11", {done, err}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ill_busy: got %b expected 0", busy); end
    checks++; if (msg_out !== PT) begin errors++; $display("FAIL ill_msg_kept: got %h expected %h", msg_out, PT); end
    @(posedge clk); #1;
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL ill_pulse_width: got %b expected 00", {done, err}); end
    repeat (20) @(posedge clk); #1;
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL ill_cs: got %b expected 1", cs); end
    checks++; if (sclk_edges != e0) begin errors++; $display("FAIL ill_sclk_edges: got %0d expected %0d", sclk_edges - e0, 0); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    do_start(2'b00, K128, CT128);
    repeat (1500) @(posedge clk);
    #1;
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL mid_in_frame: got cs=%b expected 0", cs); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (cs !== 1'b1 || sclk !== 1'b0) begin errors++; $display("FAIL mid_rst_pins: got cs=%b sclk=%b expected 1/0", cs, sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    checks++; if (msg_out !== '0) begin errors++; $display("FAIL mid_rst_msg: got %h expected 0", msg_out); end
    repeat (3) @(posedge clk);
    do_start(2'b00, K128, CT128);
    wait_done(cyc);
    checks++; if (cyc != LAT || done !== 1'b1) begin errors++; $display("FAIL mid_restart_latency: got %0d expected %0d", cyc, LAT); end
    checks++; if (msg_out !== PT) begin errors++; $display("FAIL mid_restart_msg: got %h expected %h", msg_out, PT); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_start_while_busy;
    int cyc, d0;
    d0 = done_cnt;
    do_start(2'b00, K128, CT128);
    cyc = 0;
    while (cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2130) begin key_size = 2'b11; start = 1'b1; end
      else if (cyc == 2131) start = 1'b0;
      if (done) break;
    end
    checks++; if (cyc != LAT || done !== 1'b1) begin errors++; $display("FAIL busy_start_latency: got %0d expected %0d", cyc, LAT); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL busy_start_err: got %b expected 0", err); end
    checks++; if (msg_out !== PT) begin errors++; $display("FAIL busy_start_msg: got %h expected %h", msg_out, PT); end
    repeat (10) @(posedge clk); #1;
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0 || cs !== 1'b1) begin errors++; $display("FAIL busy_start_idle: got busy=%b cs=%b expected 0/1", busy, cs); end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes256_frames();
    test_illegal();
    test_reset_mid();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
